// File: rtl/mem_pipe_stage_pkg.sv
// Shared definitions for the EXE->MEM elastic pipeline stage: default widths,
// control-bit positions and the skid buffer state encoding.
package mem_pipe_stage_pkg;

    localparam int ASIZE_DEF  = 16;
    localparam int DSIZE_DEF  = 16;
    localparam int CTRL_W_DEF = 3;
    localparam int RD_W_DEF   = 4;
    localparam int CNT_W_DEF  = 16;

    localparam int CTRL_MEMWRITE = 0;
    localparam int CTRL_MEMREAD  = 1;
    localparam int CTRL_MEMTOREG = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic two-entry valid/ready skid buffer over a flat bus. The main register
// drives the output; the skid register absorbs the one entry that arrives as
// downstream stalls, so in_ready comes from state alone.
module pipe_skid_reg
    import mem_pipe_stage_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;

    assign in_ready_o  = (state_q != ST_TWO);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = in_data_i;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    main_d = in_data_i;
                end else if (in_fire) begin
                    skid_d  = in_data_i;
                    state_d = ST_TWO;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Squash only drops the valid qualifiers; payload registers keep stale data.
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/mem_pipe_stage.sv
// Elastic EXE->MEM stage register: skid-buffered handshake, flush, bubble-safe
// memory control outputs and a saturating back-pressure counter.
module mem_pipe_stage
    import mem_pipe_stage_pkg::*;
#(
    parameter int ASIZE  = ASIZE_DEF,
    parameter int DSIZE  = DSIZE_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int RD_W   = RD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ASIZE-1:0]  in_addr,
    input  logic [DSIZE-1:0]  in_wdata,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ASIZE-1:0]  out_addr,
    output logic [DSIZE-1:0]  out_wdata,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [RD_W-1:0]   out_rd,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int W = ASIZE + DSIZE + CTRL_W + RD_W;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [W-1:0]      in_bus;
    logic [W-1:0]      out_bus;
    logic [CTRL_W-1:0] main_ctrl;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign in_bus = {in_addr, in_wdata, in_ctrl, in_rd};
    assign {out_addr, out_wdata, main_ctrl, out_rd} = out_bus;

    pipe_skid_reg #(
        .WIDTH(W)
    ) u_skid (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_bus),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_bus)
    );

    // A bubble must never carry MemWrite/MemRead into data memory.
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign stall_cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (out_valid && !out_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
